// File: rtl/servile_loader_pkg.sv
// Shared types and constants for the servile SRAM boot loader.
package servile_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_READ,
        S_DONE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/servile_byte_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word; flags the 4th byte.
module servile_byte_packer
    import servile_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [BCNT_W-1:0] cnt_q;
    logic [31:0]       word_q;

    assign word_o       = word_q;
    assign word_valid_o = push_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (push_i) begin
            word_q[8*cnt_q +: 8] <= byte_i;
            cnt_q                <= cnt_q + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/servile_mem_loader.sv
// Wishbone loader: packs a byte stream into words written to SRAM from word address 0.
// Define SERVILE_LOADER_VERIFY_EN to read back each word and raise sticky o_err on mismatch.
module servile_mem_loader
    import servile_loader_pkg::*;
#(
    parameter int aw         = 8,
    parameter int load_words = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [7:0]    i_byte_data,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_cpu_rst
);

    localparam int            WA       = aw - 2;
    localparam logic [WA-1:0] LAST_ADR = WA'(load_words - 1);

    state_e          state_q;
    logic [WA-1:0]   adr_q;  // doubles as the word count
    logic            stb_q, we_q, rdy_q, busy_q, done_q, cpu_rst_q;
    logic            clr, push, word_valid, last;
    logic [31:0]     word;

    assign push = i_byte_valid & rdy_q;
    assign clr  = i_start && (state_q == S_IDLE || state_q == S_DONE);
    assign last = (adr_q == LAST_ADR);

    servile_byte_packer u_packer (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .clr_i        (clr),
        .push_i       (push),
        .byte_i       (i_byte_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

`ifdef SERVILE_LOADER_VERIFY_EN
    logic err_q;
    assign o_err = err_q;
`else
    logic unused_rdt;
    assign unused_rdt = ^i_wb_rdt;
    assign o_err      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef SERVILE_LOADER_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (i_start) begin
                    state_q   <= S_COLLECT;
                    adr_q     <= '0;
                    rdy_q     <= 1'b1;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    cpu_rst_q <= 1'b1;
`ifdef SERVILE_LOADER_VERIFY_EN
                    err_q     <= 1'b0;
`endif
                end
                S_COLLECT: if (word_valid) begin
                    state_q <= S_WRITE;
                    rdy_q   <= 1'b0;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                end
                S_WRITE: if (i_wb_ack) begin
                    stb_q <= 1'b0;
                    we_q  <= 1'b0;
`ifdef SERVILE_LOADER_VERIFY_EN
                    state_q <= S_READ;
`else
                    if (last) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q <= S_COLLECT;
                        adr_q   <= adr_q + WA'(1);
                        rdy_q   <= 1'b1;
                    end
`endif
                end
`ifdef SERVILE_LOADER_VERIFY_EN
                // One idle cycle separates the write ack from the read strobe.
                S_READ: if (!stb_q) begin
                    stb_q <= 1'b1;
                end else if (i_wb_ack) begin
                    stb_q <= 1'b0;
                    if (i_wb_rdt != word) err_q <= 1'b1;
                    if (last) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q <= S_COLLECT;
                        adr_q   <= adr_q + WA'(1);
                        rdy_q   <= 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_byte_ready = rdy_q;
    assign o_wb_adr     = adr_q;
    assign o_wb_dat     = word;
    assign o_wb_sel     = {4{stb_q}};
    assign o_wb_we      = we_q;
    assign o_wb_stb     = stb_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_cpu_rst    = cpu_rst_q;

endmodule

// File: tb/tb_servile_mem_loader.sv
// Directed bench for servile_mem_loader: a 2-word instance and a 64-word instance on one clock.
module tb_servile_mem_loader;

    localparam int AW = 8;
`ifdef SERVILE_LOADER_VERIFY_EN
    localparam int   APW     = 2;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int   APW     = 1;
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {logic [5:0] adr; logic [31:0] dat;} wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    logic rst_a_n, rst_b_n, start_a, start_b, bv, who, rdy;
    logic [7:0] bd;

    logic        rdy_a, we_a, stb_a, busy_a, done_a, err_a, cpu_a;
    logic        ack_a = 1'b0;
    logic [5:0]  adr_a;
    logic [31:0] dat_a, rdt_a = '0;
    logic [3:0]  sel_a;
    logic        rdy_b, we_b, stb_b, busy_b, done_b, err_b, cpu_b;
    logic        ack_b = 1'b0;
    logic [5:0]  adr_b;
    logic [31:0] dat_b, rdt_b = '0;
    logic [3:0]  sel_b;

    assign rdy = who ? rdy_b : rdy_a;

    servile_mem_loader #(.aw(AW), .load_words(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_start(start_a),
        .i_byte_data(bd), .i_byte_valid(bv & ~who), .o_byte_ready(rdy_a),
        .o_wb_adr(adr_a), .o_wb_dat(dat_a), .o_wb_sel(sel_a), .o_wb_we(we_a),
        .o_wb_stb(stb_a), .i_wb_rdt(rdt_a), .i_wb_ack(ack_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_cpu_rst(cpu_a)
    );

    servile_mem_loader #(.aw(AW), .load_words(64)) u_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_start(start_b),
        .i_byte_data(bd), .i_byte_valid(bv & who), .o_byte_ready(rdy_b),
        .o_wb_adr(adr_b), .o_wb_dat(dat_b), .o_wb_sel(sel_b), .o_wb_we(we_b),
        .o_wb_stb(stb_b), .i_wb_rdt(rdt_b), .i_wb_ack(ack_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_cpu_rst(cpu_b)
    );

    // Wishbone responders: registered single-cycle ack after dly extra cycles.
    int          dly_a = 0, wait_a = 0, nacks_a = 0;
    logic        corrupt_a = 1'b0;
    logic [31:0] mem_a [64];
    wr_t         wlog_a [$];
    always @(posedge clk) begin
        ack_a <= 1'b0;
        if (stb_a && !ack_a) begin
            if (wait_a >= dly_a) begin
                ack_a   <= 1'b1;
                wait_a  <= 0;
                nacks_a <= nacks_a + 1;
                if (we_a) begin
                    mem_a[adr_a] <= dat_a;
                    wlog_a.push_back({adr_a, dat_a});
                end else begin
                    rdt_a <= mem_a[adr_a] ^ {31'd0, corrupt_a && adr_a == 6'd0};
                end
            end else begin
                wait_a <= wait_a + 1;
            end
        end
    end

    logic [31:0] mem_b [64];
    wr_t         wlog_b [$];
    always @(posedge clk) begin
        ack_b <= 1'b0;
        if (stb_b && !ack_b) begin
            ack_b <= 1'b1;
            if (we_b) begin
                mem_b[adr_b] <= dat_b;
                wlog_b.push_back({adr_b, dat_b});
            end else begin
                rdt_b <= mem_b[adr_b];
            end
        end
    end

    // Strobe-hold, byte_ready and sel monitor for the 2-word instance.
    int          hold_bad = 0, rdy_bad = 0, sel_bad = 0;
    logic        stb_prev = 1'b0, we_h = 1'b0;
    logic [5:0]  adr_h = '0;
    logic [31:0] dat_h = '0;
    always @(negedge clk) begin
        if (stb_a) begin
            if (stb_prev && (adr_a != adr_h || dat_a != dat_h || we_a != we_h)) hold_bad++;
            if (rdy_a) rdy_bad++;
            if (sel_a != 4'hf) sel_bad++;
        end else if (sel_a != 4'h0) begin
            sel_bad++;
        end
        stb_prev = stb_a;
        adr_h    = adr_a;
        dat_h    = dat_a;
        we_h     = we_a;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bd = b;
        bv = 1'b1;
        while (!rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("byte_timeout", 32'(rdy), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_acks_a(input int target, input string tag);
        int n = 0;
        while (nacks_a < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(nacks_a >= target), 32'd1);
    endtask

    task automatic pulse_start(input logic b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nb, n;
        rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        bv = 1'b0; bd = '0; who = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_stb",  stb_a,  0);
        chk("rst_we",   we_a,   0);
        chk("rst_sel",  sel_a,  0);
        chk("rst_adr",  adr_a,  0);
        chk("rst_dat",  dat_a,  0);
        chk("rst_rdy",  rdy_a,  0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err",  err_a,  0);
        chk("rst_cpu",  cpu_a,  1);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);

        // Basic two-word load
        pulse_start(1'b0);
        chk("r1_busy", busy_a, 1);
        chk("r1_rdy",  rdy_a,  1);
        chk("r1_cpu",  cpu_a,  1);
        base = wlog_a.size(); nb = nacks_a;
        send_word(32'h44332211);
        send_word(32'h88776655);
        bv = 1'b0;
        wait_acks_a(nb + 2*APW, "r1_acks");
        chk("r1_done_pre", done_a, 0);
        @(negedge clk);
        chk("r1_done",  done_a, 1);
        chk("r1_cpu0",  cpu_a,  0);
        chk("r1_busy0", busy_a, 0);
        chk("r1_err",   err_a,  0);
        chk("r1_nwr",   wlog_a.size() - base, 2);
        chk("r1_w0_adr", wlog_a[base].adr,   0);
        chk("r1_w0_dat", wlog_a[base].dat,   32'h44332211);
        chk("r1_w1_adr", wlog_a[base+1].adr, 1);
        chk("r1_w1_dat", wlog_a[base+1].dat, 32'h88776655);

        // Late and stalled acks with valid held high; start from DONE
        pulse_start(1'b0);
        chk("r2_done_clr", done_a, 0);
        chk("r2_busy",     busy_a, 1);
        hold_bad = 0; rdy_bad = 0;
        dly_a = 6;
        base = wlog_a.size(); nb = nacks_a;
        send_word(32'hA3A2A1A0);
        wait_acks_a(nb + APW, "r2_ack0");
        chk("r2_rdy_at_ack", rdy_a, 0);
        @(negedge clk);
        chk("r2_rdy_after", rdy_a, 1);
        chk("r2_stb_after", stb_a, 0);
        dly_a = 20;
        send_word(32'hB7B6B5B4);
        bv = 1'b0;
        wait_acks_a(nb + 2*APW, "r2_acks");
        @(negedge clk);
        chk("r2_done",     done_a, 1);
        chk("r2_hold",     hold_bad, 0);
        chk("r2_rdy_stb",  rdy_bad, 0);
        chk("r2_w0_dat",   wlog_a[base].dat,   32'hA3A2A1A0);
        chk("r2_w1_adr",   wlog_a[base+1].adr, 1);
        chk("r2_w1_dat",   wlog_a[base+1].dat, 32'hB7B6B5B4);

        // Start ignored mid-write, then reset during word 1
        pulse_start(1'b0);
        dly_a = 6; nb = nacks_a;
        send_word(32'h04030201);
        chk("r3_stb", stb_a, 1);
        pulse_start(1'b0);
        @(negedge clk);
        chk("r3_ign_busy", busy_a, 1);
        chk("r3_ign_stb",  stb_a,  1);
        chk("r3_ign_adr",  adr_a,  0);
        chk("r3_ign_dat",  dat_a,  32'h04030201);
        wait_acks_a(nb + APW, "r3_ack0");
        @(negedge clk);
        send_byte(8'h05);
        send_byte(8'h06);
        bd = 8'h07; bv = 1'b1;
        rst_a_n = 1'b0;
        #1;
        chk("r3_rst_stb",  stb_a,  0);
        chk("r3_rst_busy", busy_a, 0);
        chk("r3_rst_cpu",  cpu_a,  1);
        chk("r3_rst_rdy",  rdy_a,  0);
        @(negedge clk);
        rst_a_n = 1'b1; bv = 1'b0; dly_a = 0;
        @(negedge clk);
        pulse_start(1'b0);
        base = wlog_a.size(); nb = nacks_a;
        send_word(32'hC3C2C1C0);
        send_word(32'hC7C6C5C4);
        bv = 1'b0;
        wait_acks_a(nb + 2*APW, "r3_acks");
        @(negedge clk);
        chk("r3_done",   done_a, 1);
        chk("r3_nwr",    wlog_a.size() - base, 2);
        chk("r3_w0_adr", wlog_a[base].adr,   0);
        chk("r3_w0_dat", wlog_a[base].dat,   32'hC3C2C1C0);
        chk("r3_w1_dat", wlog_a[base+1].dat, 32'hC7C6C5C4);

        // Readback mismatch on word 0 (only observable with verify)
        pulse_start(1'b0);
        corrupt_a = 1'b1; nb = nacks_a;
        send_word(32'h44332211);
        send_word(32'h88776655);
        bv = 1'b0;
        wait_acks_a(nb + 2*APW, "r4_acks");
        @(negedge clk);
        chk("r4_done", done_a, 1);
        chk("r4_err",  err_a,  EXP_ERR);
        chk("r4_cpu",  cpu_a,  0);
        corrupt_a = 1'b0;
        pulse_start(1'b0);
        chk("r4_err_clr",  err_a,  0);
        chk("r4_done_clr", done_a, 0);
        chk("r4_cpu_rst",  cpu_a,  1);

        // Full 64-word load on the second instance
        who = 1'b1;
        pulse_start(1'b1);
        for (int w = 0; w < 64; w++)
            send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        bv = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_done",     done_b, 1);
        chk("b_cpu",      cpu_b,  0);
        chk("b_err",      err_b,  0);
        chk("b_nwr",      wlog_b.size(), 64);
        chk("b_first",    wlog_b[0].dat,  32'h03020100);
        chk("b_last_adr", wlog_b[63].adr, 63);
        chk("b_last_dat", wlog_b[63].dat, 32'hFFFEFDFC);
        chk("a_sel",      sel_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servile_mem_loader.md
# servile_mem_loader

Wishbone initiator that boots the shared servile SRAM from a byte stream. It collects bytes from an external byte source (UART receiver, SPI flash reader) and packs them little-endian into 32-bit words. Each word is written through the memory arbiter's Wishbone port at consecutive word addresses from 0. The CPU is held in reset until the configured number of words has been written.

## Interface
Parameters:
- `aw`, 8: SRAM byte-address width; Wishbone word address is `aw-2` bits wide.
- `load_words`, 32: number of words loaded per run; legal range 1 .. 2^(aw-2).

Ports:
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `i_start`  in  1: pulse that begins a load run; sampled only in IDLE or DONE.
- `i_byte_data`  in  8: stream byte.
- `i_byte_valid`  in  1: byte present.
- `o_byte_ready`  out  1: loader accepts a byte; transfer when valid & ready.
- `o_wb_adr`  out  aw-2: word address.
- `o_wb_dat`  out  32: write data.
- `o_wb_sel`  out  4: byte enables; 4'hf during any strobe, 0 otherwise.
- `o_wb_we`  out  1: write enable.
- `o_wb_stb`  out  1: cycle request; held until ack.
- `i_wb_rdt`  in  32: read data; used only with verify.
- `i_wb_ack`  in  1: single-cycle acknowledge.
- `o_busy`  out  1: run in progress.
- `o_done`  out  1: sticky; last word written, cleared by next start.
- `o_err`  out  1: sticky verify mismatch, cleared by start; constant 0 without verify.
- `o_cpu_rst`  out  1: CPU reset request; high from reset until DONE, high again on restart.

## Operation
- States: IDLE, COLLECT, WRITE, READ (verify only), DONE.
- IDLE:
  - `i_start` → COLLECT.
  - Word address, byte count and word count are cleared.
  - `o_done` and `o_err` are cleared.
- COLLECT:
  - `o_byte_ready` is 1.
  - Byte k (0..3) of the current word lands in `o_wb_dat[8k+7:8k]`.
  - On the 4th accepted byte → WRITE.
- WRITE:
  - `o_wb_stb`=1, `o_wb_we`=1, `o_wb_sel`=4'hf.
  - Address and data are held stable until `i_wb_ack`.
  - On ack: with verify → READ, otherwise go to the advance step.
- READ:
  - `o_wb_stb`=1, `o_wb_we`=0, same address.
  - On ack: if `i_wb_rdt` ≠ held word, set `o_err`.
  - Then go to the advance step.
- Advance step:
  - If word count = `load_words`-1 → DONE.
  - Otherwise increment address and word count → COLLECT.
- DONE: `o_done`=1, `o_cpu_rst`=0, `o_busy`=0. `i_start` restarts exactly as from IDLE.
- `o_byte_ready` is 0 in every state except COLLECT. Bytes offered then are not consumed.
- `i_start` in COLLECT, WRITE or READ is ignored.
- Address never wraps, because `load_words` ≤ 2^(aw-2) by rule. The final address is `load_words`-1.

## Timing
- All outputs are registered.
- Reset values:
  - stb, we, sel, adr, dat, byte_ready, busy, done, err: all 0.
  - `o_cpu_rst`: 1.
- Reset mid-run: asynchronously returns to IDLE. `o_wb_stb` drops immediately; partial word is discarded.
- `o_wb_stb` rises in the cycle after the 4th byte handshake.
- `o_wb_stb` is low in the cycle after ack is sampled. The arbiter's ack is registered, so no back-to-back stb/ack overlap occurs.
- With the arbiter's 4-cycle byte-serial access: minimum per word is 4 byte cycles + 1 + 4 ack latency + 1 to return to COLLECT.
- `o_wb_stb` is held through arbiter stalls (RF writes inhibit the arbiter). No timeout.
- `o_done` and `o_cpu_rst` change in the cycle after the final ack (write ack, or read ack with verify).

## Configuration
- Macro `SERVILE_LOADER_VERIFY_EN`.
- Defined:
  - READ state is compiled in; every written word is read back and compared.
  - `o_err` is sticky on any mismatch. The run still completes.
- Undefined:
  - No READ state; `i_wb_rdt` is unused.
  - `o_err` is tied to 0.

## Structure
- Package `servile_loader_pkg`:
  - State enum (IDLE, COLLECT, WRITE, READ, DONE).
  - `BYTES_PER_WORD`=4.
  - Byte-count width constant.
- Sub-module `servile_byte_packer`:
  - Owns the 2-bit byte counter and the 32-bit little-endian assembly register.
  - Outputs `word_valid` on the 4th byte.
  - Cleared by the FSM on start.

## Test plan
- Reset, then `i_start` with `load_words`=2. Stream 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88.
  - Writes 0x44332211 @adr 0, then 0x88776655 @adr 1, both with sel=4'hf.
  - `o_done`=1 and `o_cpu_rst`=0 one cycle after the 2nd ack.
- Responder acks 6 cycles late with `i_byte_valid` held high. Also stall ack 20 cycles (RF busy).
  - `o_wb_stb`, adr and dat stay constant while waiting.
  - `o_byte_ready` stays 0 until the cycle after ack.
- Deassert `i_rst_n` during the 3rd byte of word 1, then restart.
  - stb=0, busy=0, cpu_rst=1 immediately on reset.
  - Restart rewrites from adr 0.
- `i_start` pulsed during WRITE → ignored. `i_start` in DONE → done/err clear, reload from adr 0.
- Verify build: responder returns 0x44332210 for word 0.
  - `o_err`=1, sticky.
  - Run still completes with `o_done`=1.
- `load_words`=64, `aw`=8: last write at adr 63, no wrap. Without verify, `o_err` stays 0.
